// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// state  | meaning: FREE idle, BYZERO zero divisor, ON iterating, END result held
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d, busy_q, busy_d;

  logic                accept, dvd_neg, dvs_neg;
  logic [DATA_W-1:0]   dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [DATA_W:0]     rem_sh, trial;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign accept = start_i && !annul_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:   if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)                state_d = S_FREE;
        else if (cnt_q == CNT_LAST) state_d = S_END;
      end
      S_END:    if (!start_i) state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  // Magnitudes are divided; signs are restored once all iterations are done.
  always_comb begin
    dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
    dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
    dvd_abs = dvd_neg ? -opdata1_i : opdata1_i;
    dvs_abs = dvs_neg ? -opdata2_i : opdata2_i;
    rem_sh  = {rem_q, quo_q[DATA_W-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        busy_d   = accept;
        if (accept && opdata2_i != '0) begin
          rem_d     = '0;
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          cnt_d     = '0;
        end
      end
      S_BYZERO: begin
        busy_d   = 1'b0;
        result_d = '0;
        ready_d  = !annul_i;
      end
      S_ON: begin
        if (annul_i) begin
          busy_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end else begin
          rem_d = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        if (!start_i) begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level behavioural model plus directed literal checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, busy;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: truncating division, remainder takes dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Timing model: accepted request finishes after a fixed number of edges.
  int          m_phase;   // 0 idle, 1 running, 2 result held
  int          m_left;
  logic [63:0] m_res;
  logic        exp_ready, exp_busy;
  logic [63:0] exp_result;

  initial begin
    m_phase = 0; m_left = 0; m_res = '0;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_result = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = 0; exp_ready = 1'b0; exp_busy = 1'b0; exp_result = '0;
      end else begin
        case (m_phase)
          0: begin
            exp_ready = 1'b0; exp_result = '0;
            if (start && !annul) begin
              m_res    = ref_div(signed_div, op1, op2);
              m_left   = (op2 == 32'h0) ? 1 : 33;
              m_phase  = 1;
              exp_busy = 1'b1;
            end
          end
          1: begin
            if (annul) begin
              m_phase = 0; exp_busy = 1'b0;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_phase = 2; exp_busy = 1'b0; exp_ready = 1'b1; exp_result = m_res;
              end
            end
          end
          default: begin
            if (!start) begin
              m_phase = 0; exp_ready = 1'b0; exp_result = '0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (ready !== exp_ready || busy !== exp_busy || result !== exp_result) begin
        errors++;
        $display("FAIL cycle_model t=%0t: ready %b/%b busy %b/%b result %h/%h (got/expected)",
                 $time, ready, exp_ready, busy, exp_busy, result, exp_result);
      end
    end
  end

  // Called right after an edge; returns edges until ready, busy cycles and the result at ready.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output int edges, output int busy_cnt, output logic [63:0] res);
    logic [63:0] want;
    want = ref_div(sgn, a, b);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    edges = 0; busy_cnt = 0;
    while (ready !== 1'b1 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (busy === 1'b1) busy_cnt++;
    end
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready %b after %0d edges, required 1", ready, edges);
    end
    res = result;
    for (int i = 0; i < hold; i++) begin
      op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
      @(posedge clk); #1;
      chk("end_hold_ready", {63'h0, ready}, 64'h1);
      chk("end_hold_result", result, want);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", {63'h0, ready}, 64'h0);
    chk("drop_result", result, 64'h0);
  endtask

  int          e, bc;
  logic [63:0] r;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_result", result, 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100, 32'd7, 5, e, bc, r);
    chk("u100_7_result", r, 64'h00000002_0000000E);
    chk("u100_7_latency", 64'(e), 64'd34);
    chk("u100_7_busy_cycles", 64'(bc), 64'd33);

    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, e, bc, r);
    chk("s_m7_2_result", r, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1, e, bc, r);
    chk("s_7_m2_result", r, 64'h00000001_FFFFFFFD);

    run_div(1'b0, 32'd5, 32'd0, 2, e, bc, r);
    chk("byzero_result", r, 64'h0);
    chk("byzero_latency", 64'(e), 64'd2);
    chk("byzero_busy_cycles", 64'(bc), 64'd1);

    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, e, bc, r);
    chk("overflow_result", r, 64'h00000000_80000000);
    chk("overflow_latency", 64'(e), 64'd34);

    // Annul during iteration 10.
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_busy", {63'h0, busy}, 64'h0);
    chk("annul_ready", {63'h0, ready}, 64'h0);
    run_div(1'b0, 32'd9, 32'd3, 0, e, bc, r);
    chk("after_annul_result", r, 64'h00000000_00000003);
    chk("after_annul_latency", 64'(e), 64'd34);

    // Reset in the middle of an iteration run.
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_ready", {63'h0, ready}, 64'h0);
    chk("midrun_reset_busy", {63'h0, busy}, 64'h0);
    chk("midrun_reset_result", result, 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, e, bc, r);
    chk("after_reset_result", r, 64'hFFFFFFFE_FFFFFFF2);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 7) == 0) begin
        signed_div = 1'($urandom); op1 = ra; op2 = rb; start = 1'b1;
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        @(posedge clk); #1;
      end else begin
        run_div(1'($urandom), ra, rb, $urandom_range(0, 3), e, bc, r);
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider with its own sequencing FSM, serving DIV/DIVU issued from the execute stage.
- EX raises start_i with latched operands and holds its stall request until ready_o. It then forwards result_o to the HI/LO write path (HI = remainder, LO = quotient).
- annul_i lets the pipeline kill an in-flight divide on flush.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge)
- signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  divide request; EX holds it high until it consumes ready_o
- annul_i  input  1  abort the current/requested divide
- result_o  output  2*DATA_W  {remainder, quotient}
- ready_o  output  1  result_o valid
- busy_o  output  1  divide in progress (states BYZERO or ON)

Behaviour:
- All outputs registered. On reset (rst==0 at edge), regardless of state: state=FREE, counter=0, result_o=0, ready_o=0, busy_o=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0: go to BYZERO.
  - start_i=1, annul_i=0, divisor nonzero: go to ON. Latch operands; when signed_div_i=1, latch the absolute values plus the sign flags (dividend sign, sign XOR). Working register {rem,quo} = {0, |dividend|}, counter=0.
  - start_i with annul_i=1 is ignored; stay in FREE.
  - ready_o=0, result_o=0.
- BYZERO: next edge goes to END with result_o=0. Latency from start sampled to ready_o=1 is 2 edges.
- ON, one iteration per edge while counter<DATA_W:
  - Shift {rem,quo} left 1; trial = rem_shifted - divisor (DATA_W+1 bits).
  - No borrow: rem = trial, quo LSB = 1. Borrow: rem unchanged, quo LSB = 0.
  - counter increments.
- ON, counter==DATA_W: apply sign fixup and go to END.
  - Quotient negated (two's complement) if sign XOR=1.
  - Remainder negated if the dividend was negative.
  - Unsigned divides: no fixup.
- ON latency: start sampled at edge 0; ON entered at edge 1; 32 iterations at edges 2..33; fixup and ready_o=1 at edge 34 (DATA_W+2).
- Operand changes on the inputs during ON or END are ignored.
- annul_i=1 in ON or BYZERO: go to FREE on the next edge, ready_o stays 0, busy_o drops.
- annul_i in END is ignored.
- END: ready_o=1, result_o stable for as long as start_i=1. When start_i=0, next edge goes to FREE with ready_o=0 and result_o=0.
- A new divide can be accepted in the cycle after returning to FREE. There is no back-to-back END→ON path.
- busy_o=1 exactly in BYZERO and ON.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
- Simultaneous rst=0 with any input: reset wins.

Test Plan:
- Unsigned 100/7: signed_div_i=0, start_i pulse held. Required: ready_o=1 exactly 34 edges after start sampled; result_o = {0x00000002, 0x0000000E}; busy_o high for edges 1..33.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=2. Required: result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 5/0: BYZERO then END. Required: ready_o=1 two edges after start; result_o=0; busy_o high for one cycle.
- Signed overflow, 0x80000000/0xFFFFFFFF: result_o = {0x00000000, 0x80000000}, ready at edge 34.
- Annul: start 100/7, assert annul_i for one cycle at iteration 10. Required: FREE next edge, ready_o never asserts, busy_o=0. A new start (9/3) issued next cycle completes with {0, 3}.
- Handshake and reset:
  - Hold start_i 5 extra cycles in END: ready_o and result_o stay stable. Drop start_i: ready_o=0 and result_o=0 one edge later.
  - Separately, drive rst=0 mid-ON: all outputs 0 at that edge. A subsequent start behaves normally.
